// File: rtl/flash_req_arbiter_pkg.sv
// Shared constants for the two-requester flash arbiter: FSM encoding, field widths,
// watchdog defaults and the round-robin pick rule.
package flash_req_arbiter_pkg;

    localparam int DEF_MODE_W      = 2;
    localparam int DEF_TIMES_W     = 6;
    localparam int DEF_TIMEOUT_CYC = 50_000_000;
    localparam int DEF_TO_W        = 26;

    localparam int         STATE_W  = 2;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    // With both slots pending the requester not served last time wins.
    function automatic logic rr_pick(input logic [1:0] pend, input logic last_grant);
        if (pend == 2'b11) begin
            return ~last_grant;
        end
        return pend[1];
    endfunction

endpackage

// File: rtl/flash_req_arbiter_if.sv
// Request/engine bundle between two job requesters, the arbiter and one led_flash engine.
// The arbiter sits on the slave side; the requester/engine environment is the master.
interface flash_req_arbiter_if
    import flash_req_arbiter_pkg::*;
#(
    parameter int MODE_W  = DEF_MODE_W,
    parameter int TIMES_W = DEF_TIMES_W
);

    logic               req0;
    logic [MODE_W-1:0]  mode0;
    logic [TIMES_W-1:0] times0;
    logic               req1;
    logic [MODE_W-1:0]  mode1;
    logic [TIMES_W-1:0] times1;
    logic               flash_done;

    logic               en;
    logic [MODE_W-1:0]  mode;
    logic [TIMES_W-1:0] times;
    logic               grant;
    logic               busy;
    logic [1:0]         pend;
    logic               timeout_err;

    modport master (
        output req0, mode0, times0, req1, mode1, times1, flash_done,
        input  en, mode, times, grant, busy, pend, timeout_err
    );

    modport slave (
        input  req0, mode0, times0, req1, mode1, times1, flash_done,
        output en, mode, times, grant, busy, pend, timeout_err
    );

endinterface

// File: rtl/flash_req_slot.sv
// One-deep job slot for a single requester: pending flag plus latched mode/times.
// Zero-count requests are dropped; a new request beats a same-cycle clear.
module flash_req_slot
    import flash_req_arbiter_pkg::*;
#(
    parameter int MODE_W  = DEF_MODE_W,
    parameter int TIMES_W = DEF_TIMES_W
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_req,
    input  logic [MODE_W-1:0]  i_mode,
    input  logic [TIMES_W-1:0] i_times,
    input  logic               i_clr,
    output logic               o_pend,
    output logic [MODE_W-1:0]  o_mode,
    output logic [TIMES_W-1:0] o_times
);

    logic               r_pend;
    logic [MODE_W-1:0]  r_mode;
    logic [TIMES_W-1:0] r_times;
    logic               w_take;

    assign w_take = i_req && (i_times != '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pend  <= 1'b0;
            r_mode  <= '0;
            r_times <= '0;
        end else if (w_take) begin
            // Latest request wins, even over the arbiter consuming the old job.
            r_pend  <= 1'b1;
            r_mode  <= i_mode;
            r_times <= i_times;
        end else if (i_clr) begin
            r_pend  <= 1'b0;
        end
    end

    assign o_pend  = r_pend;
    assign o_mode  = r_mode;
    assign o_times = r_times;

endmodule

// File: rtl/flash_req_arbiter.sv
// Round-robin arbiter sharing one led_flash engine between two requesters, with a
// one-cycle launch pulse, held job fields and a RUN watchdog.
module flash_req_arbiter
    import flash_req_arbiter_pkg::*;
#(
    parameter int MODE_W      = DEF_MODE_W,
    parameter int TIMES_W     = DEF_TIMES_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int TO_W        = DEF_TO_W
) (
    input logic                clk,
    input logic                rst_n,
    flash_req_arbiter_if.slave bus
);

    localparam logic [TO_W-1:0] WDOG_LAST = TO_W'(TIMEOUT_CYC - 1);

    logic [STATE_W-1:0] r_state;
    logic [TO_W-1:0]    r_wdog;
    logic               r_last_grant;
    logic               r_en;
    logic [MODE_W-1:0]  r_mode;
    logic [TIMES_W-1:0] r_times;
    logic               r_grant;
    logic               r_busy;
    logic               r_timeout_err;

    logic [1:0]         w_pend;
    logic [1:0]         w_clr;
    logic [MODE_W-1:0]  w_mode0;
    logic [MODE_W-1:0]  w_mode1;
    logic [TIMES_W-1:0] w_times0;
    logic [TIMES_W-1:0] w_times1;
    logic               w_issue;
    logic               w_winner;
    logic [MODE_W-1:0]  w_win_mode;
    logic [TIMES_W-1:0] w_win_times;

    flash_req_slot #(
        .MODE_W  (MODE_W),
        .TIMES_W (TIMES_W)
    ) u_slot0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (bus.req0),
        .i_mode  (bus.mode0),
        .i_times (bus.times0),
        .i_clr   (w_clr[0]),
        .o_pend  (w_pend[0]),
        .o_mode  (w_mode0),
        .o_times (w_times0)
    );

    flash_req_slot #(
        .MODE_W  (MODE_W),
        .TIMES_W (TIMES_W)
    ) u_slot1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_req   (bus.req1),
        .i_mode  (bus.mode1),
        .i_times (bus.times1),
        .i_clr   (w_clr[1]),
        .o_pend  (w_pend[1]),
        .o_mode  (w_mode1),
        .o_times (w_times1)
    );

    // A job is only taken from IDLE, so pending work never preempts a running job.
    assign w_issue     = (r_state == ST_IDLE) && (w_pend != 2'b00);
    assign w_winner    = rr_pick(w_pend, r_last_grant);
    assign w_clr       = {w_issue && w_winner, w_issue && !w_winner};
    assign w_win_mode  = w_winner ? w_mode1  : w_mode0;
    assign w_win_times = w_winner ? w_times1 : w_times0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_wdog        <= '0;
            r_last_grant  <= 1'b1;
            r_en          <= 1'b0;
            r_mode        <= '0;
            r_times       <= '0;
            r_grant       <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_en          <= 1'b0;
            r_timeout_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_issue) begin
                        r_state      <= ST_ISSUE;
                        r_en         <= 1'b1;
                        r_busy       <= 1'b1;
                        r_mode       <= w_win_mode;
                        r_times      <= w_win_times;
                        r_grant      <= w_winner;
                        r_last_grant <= w_winner;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_RUN;
                    r_wdog  <= '0;
                end
                ST_RUN: begin
                    // Completion takes precedence over a same-cycle watchdog expiry.
                    if (bus.flash_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_wdog == WDOG_LAST) begin
                        r_state       <= ST_IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_wdog <= r_wdog + 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en          = r_en;
    assign bus.mode        = r_mode;
    assign bus.times       = r_times;
    assign bus.grant       = r_grant;
    assign bus.busy        = r_busy;
    assign bus.pend        = w_pend;
    assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_flash_req_arbiter.sv
// Bench for flash_req_arbiter: cycle vector table, directed corner sequences and
// randomized traffic against a job-level reference model.
module tb_flash_req_arbiter;

    localparam int MODE_W      = 2;
    localparam int TIMES_W     = 6;
    localparam int TIMEOUT_CYC = 20;
    localparam int TO_W        = 5;

    localparam int PH_IDLE  = 0;
    localparam int PH_ISSUE = 1;
    localparam int PH_RUN   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    flash_req_arbiter_if #(.MODE_W(MODE_W), .TIMES_W(TIMES_W)) bus ();

    flash_req_arbiter #(
        .MODE_W      (MODE_W),
        .TIMES_W     (TIMES_W),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .TO_W        (TO_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       r0;
        logic [1:0] m0;
        logic [5:0] t0;
        logic       r1;
        logic [1:0] m1;
        logic [5:0] t1;
        logic       dn;
        logic [13:0] exp;
    } vec_t;

    vec_t tbl[24];

    // Reference model state: one job slot per requester plus the job in flight.
    int         m_phase;
    bit         m_pend[2];
    logic [1:0] m_smode[2];
    logic [5:0] m_stimes[2];
    int         m_last;
    int         m_cyc;
    int         m_run_start;
    logic       e_en, e_grant, e_busy, e_to;
    logic [1:0] e_mode, e_pend;
    logic [5:0] e_times;

    logic       in_r0, in_r1, in_done;
    logic [1:0] in_m0, in_m1;
    logic [5:0] in_t0, in_t1;

    function automatic logic [13:0] pk(input logic en, input logic [1:0] mode, input logic [5:0] times,
                                       input logic grant, input logic busy, input logic [1:0] pend,
                                       input logic to);
        return {en, mode, times, grant, busy, pend, to};
    endfunction

    function automatic logic [13:0] act();
        return {bus.en, bus.mode, bus.times, bus.grant, bus.busy, bus.pend, bus.timeout_err};
    endfunction

    function automatic vec_t v(input logic r0, input logic [1:0] m0, input logic [5:0] t0,
                               input logic r1, input logic [1:0] m1, input logic [5:0] t1,
                               input logic dn, input logic [13:0] exp);
        vec_t x;
        x.r0 = r0; x.m0 = m0; x.t0 = t0;
        x.r1 = r1; x.m1 = m1; x.t1 = t1;
        x.dn = dn; x.exp = exp;
        return x;
    endfunction

    task automatic check(input string name, input logic [13:0] a, input logic [13:0] e);
        n_total++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %04h expected %04h (en,mode,times,grant,busy,pend,to)", name, a, e);
    endtask

    task automatic check_int(input string name, input int a, input int e);
        n_total++;
        if (a == e) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, a, e);
    endtask

    task automatic drive(input logic r0, input logic [1:0] m0, input logic [5:0] t0,
                         input logic r1, input logic [1:0] m1, input logic [5:0] t1, input logic dn);
        bus.req0 = r0; bus.mode0 = m0; bus.times0 = t0;
        bus.req1 = r1; bus.mode1 = m1; bus.times1 = t1;
        bus.flash_done = dn;
    endtask

    task automatic idle_in();
        drive(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_in();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_en(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (bus.en === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_reset();
        m_phase = PH_IDLE;
        m_pend[0] = 0; m_pend[1] = 0;
        m_smode[0] = '0; m_smode[1] = '0;
        m_stimes[0] = '0; m_stimes[1] = '0;
        m_last = 1; m_cyc = 0; m_run_start = 0;
        e_en = 0; e_grant = 0; e_busy = 0; e_to = 0;
        e_mode = '0; e_times = '0; e_pend = '0;
    endtask

    // Advance the model across one clock edge using the inputs presented before it.
    task automatic model_step();
        int win;
        win  = -1;
        e_en = 1'b0;
        e_to = 1'b0;
        case (m_phase)
            PH_IDLE: begin
                if (m_pend[0] || m_pend[1]) begin
                    if (m_pend[0] && m_pend[1]) win = 1 - m_last;
                    else                        win = m_pend[1] ? 1 : 0;
                    e_mode  = m_smode[win];
                    e_times = m_stimes[win];
                    e_grant = (win == 1);
                    m_last  = win;
                    e_en    = 1'b1;
                    e_busy  = 1'b1;
                    m_phase = PH_ISSUE;
                end
            end
            PH_ISSUE: begin
                m_phase     = PH_RUN;
                m_run_start = m_cyc + 1;
            end
            PH_RUN: begin
                if (in_done) begin
                    m_phase = PH_IDLE;
                    e_busy  = 1'b0;
                end else if (m_cyc - m_run_start == TIMEOUT_CYC - 1) begin
                    m_phase = PH_IDLE;
                    e_busy  = 1'b0;
                    e_to    = 1'b1;
                end
            end
            default: ;
        endcase
        if (win >= 0) m_pend[win] = 0;
        if (in_r0 && in_t0 != 6'd0) begin
            m_pend[0] = 1; m_smode[0] = in_m0; m_stimes[0] = in_t0;
        end
        if (in_r1 && in_t1 != 6'd0) begin
            m_pend[1] = 1; m_smode[1] = in_m1; m_stimes[1] = in_t1;
        end
        e_pend = {m_pend[1], m_pend[0]};
        m_cyc++;
    endtask

    initial begin
        #2ms;
        $display("FAIL tb_timeout: simulation exceeded its time budget");
        $fatal(1);
    end

    initial begin
        bit found;
        int n;

        // Rows: inputs for one cycle, then outputs expected just after that edge.
        tbl[0]  = v(1'b1, 2'd1, 6'd3, 1'b1, 2'd3, 6'd9, 1'b0, pk(1'b0, 2'd0, 6'd0, 1'b0, 1'b0, 2'b11, 1'b0));
        tbl[1]  = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b1, 2'd1, 6'd3, 1'b0, 1'b1, 2'b10, 1'b0));
        tbl[2]  = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b0, 2'd1, 6'd3, 1'b0, 1'b1, 2'b10, 1'b0));
        tbl[3]  = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd1, 6'd3, 1'b0, 1'b0, 2'b10, 1'b0));
        tbl[4]  = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b1, 2'd3, 6'd9, 1'b1, 1'b1, 2'b00, 1'b0));
        tbl[5]  = v(1'b0, 2'd0, 6'd0, 1'b1, 2'd2, 6'd0, 1'b0, pk(1'b0, 2'd3, 6'd9, 1'b1, 1'b1, 2'b00, 1'b0));
        tbl[6]  = v(1'b1, 2'd2, 6'd4, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b0, 2'd3, 6'd9, 1'b1, 1'b1, 2'b01, 1'b0));
        tbl[7]  = v(1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 6'd6, 1'b0, pk(1'b0, 2'd3, 6'd9, 1'b1, 1'b1, 2'b11, 1'b0));
        tbl[8]  = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd3, 6'd9, 1'b1, 1'b0, 2'b11, 1'b0));
        tbl[9]  = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b1, 2'd2, 6'd4, 1'b0, 1'b1, 2'b10, 1'b0));
        tbl[10] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd2, 6'd4, 1'b0, 1'b1, 2'b10, 1'b0));
        tbl[11] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd2, 6'd4, 1'b0, 1'b0, 2'b10, 1'b0));
        tbl[12] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b1, 2'd1, 6'd6, 1'b1, 1'b1, 2'b00, 1'b0));
        tbl[13] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b0, 2'd1, 6'd6, 1'b1, 1'b1, 2'b00, 1'b0));
        tbl[14] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd1, 6'd6, 1'b1, 1'b0, 2'b00, 1'b0));
        tbl[15] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd1, 6'd6, 1'b1, 1'b0, 2'b00, 1'b0));
        tbl[16] = v(1'b0, 2'd0, 6'd0, 1'b1, 2'd0, 6'd0, 1'b0, pk(1'b0, 2'd1, 6'd6, 1'b1, 1'b0, 2'b00, 1'b0));
        tbl[17] = v(1'b1, 2'd1, 6'd2, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b0, 2'd1, 6'd6, 1'b1, 1'b0, 2'b01, 1'b0));
        tbl[18] = v(1'b1, 2'd3, 6'd7, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b1, 2'd1, 6'd2, 1'b0, 1'b1, 2'b01, 1'b0));
        tbl[19] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b0, 2'd1, 6'd2, 1'b0, 1'b1, 2'b01, 1'b0));
        tbl[20] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd1, 6'd2, 1'b0, 1'b0, 2'b01, 1'b0));
        tbl[21] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b0, pk(1'b1, 2'd3, 6'd7, 1'b0, 1'b1, 2'b00, 1'b0));
        tbl[22] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd3, 6'd7, 1'b0, 1'b1, 2'b00, 1'b0));
        tbl[23] = v(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1, pk(1'b0, 2'd3, 6'd7, 1'b0, 1'b0, 2'b00, 1'b0));

        do_reset();
        check("reset_state", act(), 14'd0);

        for (int i = 0; i < 24; i++) begin
            drive(tbl[i].r0, tbl[i].m0, tbl[i].t0, tbl[i].r1, tbl[i].m1, tbl[i].t1, tbl[i].dn);
            tick();
            check($sformatf("tbl%0d", i), act(), tbl[i].exp);
        end
        idle_in();

        // Single job latency and completion.
        do_reset();
        drive(1'b1, 2'd2, 6'd5, 1'b0, 2'd0, 6'd0, 1'b0);
        tick();
        idle_in();
        check_int("lat_n1_en", int'(bus.en), 0);
        check_int("lat_n1_pend", int'(bus.pend), 1);
        tick();
        check("lat_n2_issue", act(), pk(1'b1, 2'd2, 6'd5, 1'b0, 1'b1, 2'b00, 1'b0));
        tick();
        check_int("lat_run_en_low", int'(bus.en), 0);
        repeat (8) tick();
        check_int("lat_run_busy", int'(bus.busy), 1);
        bus.flash_done = 1'b1;
        tick();
        idle_in();
        check("lat_done_idle", act(), pk(1'b0, 2'd2, 6'd5, 1'b0, 1'b0, 2'b00, 1'b0));

        // Repeated request while busy: only the later values survive.
        drive(1'b1, 2'd1, 6'd4, 1'b0, 2'd0, 6'd0, 1'b0);
        tick();
        idle_in();
        tick();
        tick();
        drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 6'd3, 1'b0);
        tick();
        check_int("ovr_pend_a", int'(bus.pend), 2);
        drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd2, 6'd7, 1'b0);
        tick();
        check_int("ovr_pend_b", int'(bus.pend), 2);
        drive(1'b0, 2'd0, 6'd0, 1'b0, 2'd0, 6'd0, 1'b1);
        tick();
        idle_in();
        wait_en(5, found);
        check_int("ovr_en_seen", int'(found), 1);
        check("ovr_job", act(), pk(1'b1, 2'd2, 6'd7, 1'b1, 1'b1, 2'b00, 1'b0));
        tick();
        check_int("ovr_en_one_cycle", int'(bus.en), 0);
        bus.flash_done = 1'b1;
        tick();
        idle_in();
        n = 0;
        repeat (6) begin
            tick();
            if (bus.en === 1'b1) n++;
        end
        check_int("ovr_no_extra_job", n, 0);

        // Watchdog abort, then the pending job is served.
        do_reset();
        drive(1'b1, 2'd1, 6'd4, 1'b0, 2'd0, 6'd0, 1'b0);
        tick();
        idle_in();
        wait_en(5, found);
        check_int("wd_en_seen", int'(found), 1);
        drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd2, 6'd3, 1'b0);
        tick();
        idle_in();
        n = 1;
        while (bus.timeout_err !== 1'b1 && n < 60) begin
            tick();
            n++;
        end
        check_int("wd_abort_cycle", n, TIMEOUT_CYC + 1);
        check("wd_abort_state", act(), pk(1'b0, 2'd1, 6'd4, 1'b0, 1'b0, 2'b10, 1'b1));
        tick();
        check("wd_next_job", act(), pk(1'b1, 2'd2, 6'd3, 1'b1, 1'b1, 2'b00, 1'b0));

        // Asynchronous reset in the middle of a run with a job pending.
        do_reset();
        drive(1'b1, 2'd3, 6'd5, 1'b0, 2'd0, 6'd0, 1'b0);
        tick();
        idle_in();
        tick();
        tick();
        drive(1'b0, 2'd0, 6'd0, 1'b1, 2'd1, 6'd2, 1'b0);
        tick();
        idle_in();
        check("arst_before", act(), pk(1'b0, 2'd3, 6'd5, 1'b0, 1'b1, 2'b10, 1'b0));
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_async_clear", act(), 14'd0);
        #2;
        rst_n = 1'b1;
        n = 0;
        repeat (10) begin
            tick();
            if (bus.en === 1'b1 || bus.pend !== 2'b00) n++;
        end
        check_int("arst_no_job", n, 0);

        // Randomized traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            in_r0   = ($urandom_range(0, 7) == 0);
            in_m0   = 2'($urandom);
            in_t0   = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            in_r1   = ($urandom_range(0, 7) == 0);
            in_m1   = 2'($urandom);
            in_t1   = ($urandom_range(0, 4) == 0) ? 6'd0 : 6'($urandom_range(1, 63));
            in_done = ($urandom_range(0, 17) == 0);
            drive(in_r0, in_m0, in_t0, in_r1, in_m1, in_t1, in_done);
            model_step();
            tick();
            check($sformatf("rand%0d", c), act(), pk(e_en, e_mode, e_times, e_grant, e_busy, e_pend, e_to));
        end
        idle_in();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
